// File: rtl/audio_interval_stats_stream_if.sv
// rtl/audio_interval_stats_stream_if.sv - sample-in / result-out stream bundle for audio_interval_stats_stream
//
// Purpose: groups the input sample stream and the output result stream of
// audio_interval_stats_stream into one interface.
// Signals:
//   in_valid/in_ready/in_data        : one beat = one sample per lane, lane k at [k*DATA_W +: DATA_W]
//   out_valid/out_ready              : result handshake
//   out_min/out_max                  : per-lane signed min / max, CH*DATA_W
//   out_p2p                          : per-lane unsigned max-min, CH*(DATA_W+1)
//   out_idx/out_count                : interval index and number of samples in it
// Modports: slave = the statistics block, master = the sample source / result sink.

interface audio_interval_stats_stream_if #(
    parameter int DATA_W = 32,
    parameter int CH     = 2,
    parameter int LEN_W  = 16,
    parameter int CNT_W  = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic [CH*DATA_W-1:0]       in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [CH*DATA_W-1:0]       out_min;
    logic [CH*DATA_W-1:0]       out_max;
    logic [CH*(DATA_W+1)-1:0]   out_p2p;
    logic [CNT_W-1:0]           out_idx;
    logic [LEN_W-1:0]           out_count;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_min, out_max, out_p2p, out_idx, out_count
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_min, out_max, out_p2p, out_idx, out_count
    );
endinterface

// File: rtl/audio_interval_stats_stream.sv
// rtl/audio_interval_stats_stream.sv - streaming per-lane interval min/max/peak-to-peak
//
// Purpose: splits a multi-lane signed sample stream into intervals of
// interval_len samples and emits per-lane min, max and max-min for each one.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   start             : starts a run (accepted in IDLE or DONE)
//   interval_len      : samples per interval, latched on start (0 means 1)
//   num_intervals     : intervals per run, latched on start (0 finishes at once)
//   flush             : closes a non-empty partial interval while running
//   done              : run complete, level
//   bus (slave)       : input sample stream and output result stream

module audio_interval_stats_stream #(
    parameter int DATA_W = 32,
    parameter int CH     = 2,
    parameter int LEN_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_W-1:0]     interval_len,
    input  logic [CNT_W-1:0]     num_intervals,
    input  logic                 flush,
    output logic                 done,
    audio_interval_stats_stream_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [LEN_W-1:0]         len_q;
    logic [CNT_W-1:0]         nint_q;
    logic [LEN_W-1:0]         cnt;
    logic [CNT_W-1:0]         idx;
    logic [CH*DATA_W-1:0]     min_acc, max_acc;
    logic [CH*DATA_W-1:0]     min_nx, max_nx;
    logic [CH*(DATA_W+1)-1:0] p2p_nx;

    logic beat;
    logic close_iv;
    logic handshake;
    logic launch;

    // Handshake flags come straight from the state register, so neither
    // in_ready nor out_valid has a combinational path from the stream inputs.
    assign bus.in_ready  = (state == S_RUN);
    assign bus.out_valid = (state == S_EMIT);
    assign done          = (state == S_DONE);

    assign beat      = bus.in_valid && (state == S_RUN);
    assign handshake = bus.out_ready && (state == S_EMIT);
    assign launch    = start && ((state == S_IDLE) || (state == S_DONE));

    // Closing on flush looks at the count before this cycle's beat, so an
    // empty interval is never emitted but a coincident beat is still counted.
    assign close_iv = (state == S_RUN) &&
                      ((beat && (cnt == len_q - 1'b1)) || (flush && (cnt != '0)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nx = (num_intervals == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (close_iv) begin
                    state_nx = S_EMIT;
                end
            end
            S_EMIT: begin
                if (bus.out_ready) begin
                    state_nx = (idx == nint_q - 1'b1) ? S_DONE : S_RUN;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Per-lane accumulator update including the current beat. The first
    // beat of an interval loads min and max directly.
    always_comb begin
        min_nx = min_acc;
        max_nx = max_acc;
        p2p_nx = '0;
        for (int k = 0; k < CH; k++) begin
            if (beat) begin
                if ((cnt == '0) ||
                    ($signed(bus.in_data[k*DATA_W +: DATA_W]) < $signed(min_acc[k*DATA_W +: DATA_W]))) begin
                    min_nx[k*DATA_W +: DATA_W] = bus.in_data[k*DATA_W +: DATA_W];
                end
                if ((cnt == '0) ||
                    ($signed(bus.in_data[k*DATA_W +: DATA_W]) > $signed(max_acc[k*DATA_W +: DATA_W]))) begin
                    max_nx[k*DATA_W +: DATA_W] = bus.in_data[k*DATA_W +: DATA_W];
                end
            end
            // One extra bit after sign extension keeps max-min exact and non-negative.
            p2p_nx[k*(DATA_W+1) +: (DATA_W+1)] =
                {max_nx[k*DATA_W + DATA_W - 1], max_nx[k*DATA_W +: DATA_W]} -
                {min_nx[k*DATA_W + DATA_W - 1], min_nx[k*DATA_W +: DATA_W]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q         <= '0;
            nint_q        <= '0;
            cnt           <= '0;
            idx           <= '0;
            min_acc       <= '0;
            max_acc       <= '0;
            bus.out_min   <= '0;
            bus.out_max   <= '0;
            bus.out_p2p   <= '0;
            bus.out_idx   <= '0;
            bus.out_count <= '0;
        end else begin
            if (launch) begin
                len_q  <= (interval_len == '0) ? LEN_W'(1) : interval_len;
                nint_q <= num_intervals;
                cnt    <= '0;
                idx    <= '0;
            end
            if (beat) begin
                min_acc <= min_nx;
                max_acc <= max_nx;
                cnt     <= cnt + LEN_W'(1);
            end
            if (close_iv) begin
                bus.out_min   <= min_nx;
                bus.out_max   <= max_nx;
                bus.out_p2p   <= p2p_nx;
                bus.out_idx   <= idx;
                bus.out_count <= cnt + LEN_W'(beat);
            end
            if (handshake) begin
                idx <= idx + CNT_W'(1);
                cnt <= '0;
            end
        end
    end

endmodule

// File: doc/audio_interval_stats_stream.md
# audio_interval_stats_stream

Streaming, multi-channel successor to the array-based interval min/max block. It accepts one sample per channel per beat over a valid/ready input and splits the stream into intervals of `interval_len` samples. For each interval it emits the per-channel signed minimum, maximum and peak-to-peak over a valid/ready output. It sits between the audio sample source and the downstream feature/envelope logic, and removes the need to hold a whole capture in a port array.

## Interface
- `DATA_W`, default 32: signed sample width per channel.
- `CH`, default 2: number of parallel channels (lanes).
- `LEN_W`, default 16: width of interval length and sample counters.
- `CNT_W`, default 16: width of interval count and index.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that starts a run; sampled only in IDLE or DONE.
- `interval_len`  in  LEN_W  samples per interval; latched on `start`.
- `num_intervals`  in  CNT_W  intervals per run; latched on `start`.
- `flush`  in  1  closes the current partial interval; sampled only in RUN.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  CH*DATA_W  lane k is bits [k*DATA_W +: DATA_W], signed.
- `out_valid`  out  1  result beat valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_min`  out  CH*DATA_W  per-lane signed minimum.
- `out_max`  out  CH*DATA_W  per-lane signed maximum.
- `out_p2p`  out  CH*(DATA_W+1)  per-lane max−min, unsigned.
- `out_idx`  out  CNT_W  interval index, starting at 0.
- `out_count`  out  LEN_W  number of samples in this interval.
- `done`  out  1  run complete; level signal.

## Operation
- FSM states are IDLE, RUN, EMIT and DONE. `reset` forces IDLE from any state.
- Reset values: `in_ready`=0, `out_valid`=0, `done`=0. All other outputs, counters and accumulators are 0.
- IDLE/DONE → RUN on `start`:
  - Latch `interval_len`. A value of 0 is treated as 1.
  - Latch `num_intervals`. If it is 0, go directly to DONE instead of RUN.
  - Clear the sample count and interval index. Clear `done`.
- RUN:
  - `in_ready`=1.
  - On a beat (`in_valid & in_ready`) with sample count 0, each lane's min and max load directly from that lane's data.
  - On any other beat, the accumulators are updated with a signed compare: min=min(min,x) and max=max(max,x).
  - The sample count increments on every beat.
- Closing an interval:
  - The interval closes on the beat where the count reaches `interval_len`−1. The final values include that beat.
  - It also closes on `flush` when the count is >0. If `flush` and a beat coincide, the beat is included.
  - `flush` with count 0 is ignored.
  - On close: capture the results into the output registers, set `out_count` to the number of samples, and enter EMIT.
- EMIT:
  - `in_ready`=0 and `out_valid`=1.
  - Outputs hold stable until `out_valid & out_ready`.
  - On handshake: increment the interval index and clear the sample count. Go to DONE if the index was `num_intervals`−1, otherwise return to RUN.
- DONE:
  - `done`=1, held until the next `start` or `reset`.
  - `in_ready`=0 and `out_valid`=0.
- Arithmetic: `out_p2p` = sign-extended max minus sign-extended min at DATA_W+1 bits. It never overflows and is always ≥0.
- `start` during RUN or EMIT is ignored.

## Timing
- Result latency: the closing beat is accepted at edge N, and `out_valid`=1 and the results are valid after edge N.
- With `out_ready` held at 1, the EMIT→RUN handshake happens at edge N+1 and `in_ready`=1 again after it. Steady-state throughput is therefore `interval_len` beats per `interval_len`+1 cycles.
- `in_ready` and `out_valid` are registered, derived from state only. Neither depends combinationally on `in_valid` or `out_ready`.
- `done` rises the cycle after the final output handshake.
- Reset asserted mid-run or mid-EMIT clears everything asynchronously. Any pending result is dropped: `out_valid` falls immediately.

## Test plan
- **Ramp:** CH=2, lane0=i and lane1=−i for i=0..99, len 10, 10 intervals, `out_ready`=1.
  - Interval k: lane0 min=10k, max=10k+9, p2p=9.
  - Interval k: lane1 min=−(10k+9), max=−10k, p2p=9.
  - `out_idx`=k, `out_count`=10, then `done`=1.
- **Constant and alternating:**
  - All samples 42 → every interval min=max=42, p2p=0.
  - Samples alternating −100/100 → min=−100, max=100, p2p=200.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in EMIT.
  - `in_ready`=0 throughout and outputs unchanged.
  - No sample is lost; the next interval still reports correct values.
- **Flush and extremes:**
  - len 10; after 4 samples {3,−7,5,1}, pulse `flush` → min −7, max 5, p2p 12, `out_count`=4.
  - DATA_W=8 with samples −128 and 127 → p2p=255.
- **Degenerate parameters:**
  - `interval_len`=0 → each beat emits min=max=sample, `out_count`=1.
  - `num_intervals`=0 → `done`=1 one cycle after `start`, and no output is emitted.
- **Reset mid-run:**
  - Assert `reset` during the third interval → all outputs 0 and state IDLE.
  - A new `start` then reproduces the Ramp results from `out_idx`=0.
